lsu_queue: RTL and testbench

Parametrised load/store unit that replaces the core's single-outstanding 2-bit memory-stage tracker. It queues core memory requests in a request FIFO and issues them to data memory using the existing valid/yumi handshake. It allows up to MAX_INFLIGHT_P requests in flight and returns responses to the core in order, tagged. It sits between the core datapath and the data-memory port.

---
 rtl/lsu_queue.sv | 166 ++++++++++++++++
 tb/tb_lsu_queue.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_queue.sv
// Load/store queue: request FIFO feeding dmem, in-order tagged responses, flush with response discard.
// Optional LSU_PERF_CNT_EN adds load/store completion and request-stall counters.
module lsu_queue #(
    parameter int REQ_DEPTH_P    = 4,
    parameter int MAX_INFLIGHT_P = 2,
    parameter int TAG_WIDTH_P    = 4
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   req_v_i,
    output logic                                   req_ready_o,
    input  logic                                   req_wen_i,
    input  logic                                   req_byte_i,
    input  logic [31:0]                            req_addr_i,
    input  logic [31:0]                            req_data_i,
    input  logic [TAG_WIDTH_P-1:0]                 req_tag_i,
    input  logic                                   flush_i,
    output logic                                   mem_v_o,
    output logic                                   mem_wen_o,
    output logic                                   mem_byte_o,
    output logic [31:0]                            mem_addr_o,
    output logic [31:0]                            mem_data_o,
    input  logic                                   mem_yumi_i,
    input  logic                                   mem_resp_v_i,
    input  logic [31:0]                            mem_resp_data_i,
    output logic                                   mem_resp_yumi_o,
    output logic                                   resp_v_o,
    output logic [31:0]                            resp_data_o,
    output logic [TAG_WIDTH_P-1:0]                 resp_tag_o,
    output logic                                   resp_is_store_o,
    input  logic                                   resp_ready_i,
    output logic [$clog2(MAX_INFLIGHT_P+1)-1:0]    inflight_o,
    output logic                                   busy_o,
    output logic                                   exception_o
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]                            perf_loads_o,
    output logic [31:0]                            perf_stores_o,
    output logic [31:0]                            perf_stall_o
`endif
);

    localparam int AW = $clog2(REQ_DEPTH_P);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_INFLIGHT_P + 1);
    localparam int TW = (MAX_INFLIGHT_P > 1) ? $clog2(MAX_INFLIGHT_P) : 1;

    typedef struct packed {
        logic                   wen;
        logic                   byte_acc;
        logic [31:0]            addr;
        logic [31:0]            data;
        logic [TAG_WIDTH_P-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [TAG_WIDTH_P-1:0] tag;
        logic                   wen;
    } tag_t;

    req_t          req_mem [REQ_DEPTH_P];
    tag_t          tag_mem [MAX_INFLIGHT_P];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] tag_wr, tag_rd;
    logic [CW-1:0] inflight, inflight_nxt, discard_cnt;
    logic          exc;
    logic          full, empty, push, issue, resp_pop, discarding;
    req_t          head;
    tag_t          tag_head;

    function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] idx);
        return (idx == TW'(MAX_INFLIGHT_P - 1)) ? '0 : idx + TW'(1);
    endfunction

    // Full when the wrap bits differ but the indices match.
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = req_mem[rd_ptr[AW-1:0]];
    assign tag_head = tag_mem[tag_rd];

    assign discarding = (discard_cnt != '0);
    assign push       = req_v_i && !full && !flush_i;
    assign issue      = mem_v_o && mem_yumi_i;
    assign resp_pop   = mem_resp_yumi_o;

    assign req_ready_o = !full;
    assign mem_v_o     = !empty && (inflight < CW'(MAX_INFLIGHT_P)) && !flush_i;
    assign mem_wen_o   = head.wen;
    assign mem_byte_o  = head.byte_acc;
    assign mem_addr_o  = head.addr;
    assign mem_data_o  = head.data;

    // A response with nothing outstanding is never acknowledged; it only raises the exception.
    assign mem_resp_yumi_o = mem_resp_v_i && (inflight != '0) && (resp_ready_i || discarding);
    assign resp_v_o        = mem_resp_v_i && !discarding && (inflight != '0);
    assign resp_data_o     = tag_head.wen ? 32'h0 : mem_resp_data_i;
    assign resp_tag_o      = tag_head.tag;
    assign resp_is_store_o = tag_head.wen;

    assign inflight_o  = inflight;
    assign busy_o      = !empty || (inflight != '0);
    assign exception_o = exc;

    always_comb begin
        inflight_nxt = inflight;
        if (issue && !resp_pop) begin
            inflight_nxt = inflight + CW'(1);
        end else if (!issue && resp_pop) begin
            inflight_nxt = inflight - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            req_mem[wr_ptr[AW-1:0]] <= '{wen: req_wen_i, byte_acc: req_byte_i, addr: req_addr_i,
                                         data: req_data_i, tag: req_tag_i};
        end
        if (issue) begin
            tag_mem[tag_wr] <= '{tag: head.tag, wen: head.wen};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            tag_wr      <= '0;
            tag_rd      <= '0;
            inflight    <= '0;
            discard_cnt <= '0;
            exc         <= 1'b0;
        end else begin
            // Flush never coincides with an issue, so the read pointer just catches up.
            if (flush_i) begin
                rd_ptr <= wr_ptr;
            end else begin
                if (push)  wr_ptr <= wr_ptr + PW'(1);
                if (issue) rd_ptr <= rd_ptr + PW'(1);
            end
            if (issue)    tag_wr <= tag_inc(tag_wr);
            if (resp_pop) tag_rd <= tag_inc(tag_rd);
            inflight <= inflight_nxt;
            if (flush_i) begin
                discard_cnt <= inflight_nxt;
            end else if (resp_pop && discarding) begin
                discard_cnt <= discard_cnt - CW'(1);
            end
            if (mem_resp_v_i && (inflight == '0)) exc <= 1'b1;
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_loads_o  <= '0;
            perf_stores_o <= '0;
            perf_stall_o  <= '0;
        end else begin
            if (resp_v_o && resp_ready_i && !tag_head.wen) perf_loads_o  <= perf_loads_o + 32'd1;
            if (resp_v_o && resp_ready_i && tag_head.wen)  perf_stores_o <= perf_stores_o + 32'd1;
            if (req_v_i && !req_ready_o)                   perf_stall_o  <= perf_stall_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lsu_queue.sv
// Directed self-checking bench for lsu_queue with default parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
module tb_lsu_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_v, req_ready, req_wen, req_byte;
    logic [31:0] req_addr, req_data;
    logic [3:0]  req_tag;
    logic        flush;
    logic        mem_v, mem_wen, mem_byte, mem_yumi;
    logic [31:0] mem_addr, mem_data;
    logic        mem_resp_v, mem_resp_yumi;
    logic [31:0] mem_resp_data;
    logic        resp_v, resp_is_store, resp_ready;
    logic [31:0] resp_data;
    logic [3:0]  resp_tag;
    logic [1:0]  inflight;
    logic        busy, exception;
`ifdef LSU_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_stall;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_queue dut (
        .clk             (clk),
        .reset           (reset),
        .req_v_i         (req_v),
        .req_ready_o     (req_ready),
        .req_wen_i       (req_wen),
        .req_byte_i      (req_byte),
        .req_addr_i      (req_addr),
        .req_data_i      (req_data),
        .req_tag_i       (req_tag),
        .flush_i         (flush),
        .mem_v_o         (mem_v),
        .mem_wen_o       (mem_wen),
        .mem_byte_o      (mem_byte),
        .mem_addr_o      (mem_addr),
        .mem_data_o      (mem_data),
        .mem_yumi_i      (mem_yumi),
        .mem_resp_v_i    (mem_resp_v),
        .mem_resp_data_i (mem_resp_data),
        .mem_resp_yumi_o (mem_resp_yumi),
        .resp_v_o        (resp_v),
        .resp_data_o     (resp_data),
        .resp_tag_o      (resp_tag),
        .resp_is_store_o (resp_is_store),
        .resp_ready_i    (resp_ready),
        .inflight_o      (inflight),
        .busy_o          (busy),
        .exception_o     (exception)
`ifdef LSU_PERF_CNT_EN
        ,
        .perf_loads_o    (perf_loads),
        .perf_stores_o   (perf_stores),
        .perf_stall_o    (perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        req_v = 0; req_wen = 0; req_byte = 0; req_addr = 0; req_data = 0; req_tag = 0;
        flush = 0; mem_yumi = 0; mem_resp_v = 0; mem_resp_data = 0; resp_ready = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_mem_v", 32'(mem_v), 0);
        chk("rst_resp_v", 32'(resp_v), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_inflight", 32'(inflight), 0);
        chk("rst_exc", 32'(exception), 0);
        tick();
        reset = 1'b1;
        tick();

        // Single load
        req_v = 1; req_addr = 32'h10; req_tag = 4'd3; req_wen = 0; req_data = 32'h0;
        #2;
        chk("t1_mem_v_same_cycle", 32'(mem_v), 0);
        tick();
        req_v = 0;
        #2;
        chk("t1_mem_v", 32'(mem_v), 1);
        chk("t1_mem_addr", mem_addr, 32'h10);
        chk("t1_mem_wen", 32'(mem_wen), 0);
        mem_yumi = 1;
        tick();
        mem_yumi = 0;
        #2;
        chk("t1_inflight1", 32'(inflight), 1);
        chk("t1_mem_v_after", 32'(mem_v), 0);
        tick();
        mem_resp_v = 1; mem_resp_data = 32'hDEADBEEF; resp_ready = 1;
        #2;
        chk("t1_resp_v", 32'(resp_v), 1);
        chk("t1_resp_data", resp_data, 32'hDEADBEEF);
        chk("t1_resp_tag", 32'(resp_tag), 3);
        chk("t1_resp_store", 32'(resp_is_store), 0);
        chk("t1_resp_yumi", 32'(mem_resp_yumi), 1);
        tick();
        mem_resp_v = 0;
        #2;
        chk("t1_inflight0", 32'(inflight), 0);
        chk("t1_busy", 32'(busy), 0);

        // Six pushes against a stalled dmem; odd entries are stores
        for (int i = 0; i < 6; i++) begin
            req_v = 1; req_addr = 32'h100 + 32'(4 * i); req_tag = 4'(i);
            req_wen = 1'(i & 1); req_data = 32'hA0 + 32'(i);
            #2;
            chk($sformatf("t2_ready_%0d", i), 32'(req_ready), (i < 4) ? 1 : 0);
            if (i > 0) chk($sformatf("t2_head_%0d", i), mem_addr, 32'h100);
            tick();
        end
        req_v = 0;
        #2;
        chk("t2_mem_v", 32'(mem_v), 1);
        chk("t2_head_stable", mem_addr, 32'h100);
        mem_yumi = 1;
        tick();
        #2;
        chk("t2_head1_addr", mem_addr, 32'h104);
        chk("t2_head1_wen", 32'(mem_wen), 1);
        chk("t2_head1_data", mem_data, 32'hA1);
        tick();
        mem_yumi = 0;
        #2;
        chk("t3_mem_v_cap", 32'(mem_v), 0);
        chk("t3_inflight2", 32'(inflight), 2);
        mem_resp_v = 1; mem_resp_data = 32'h11111111; resp_ready = 1;
        #2;
        chk("t3_resp0_v", 32'(resp_v), 1);
        chk("t3_resp0_tag", 32'(resp_tag), 0);
        chk("t3_resp0_data", resp_data, 32'h11111111);
        tick();
        mem_yumi = 1; mem_resp_data = 32'h22222222;
        #2;
        chk("t3_mem_v_reopen", 32'(mem_v), 1);
        chk("t3_head2_addr", mem_addr, 32'h108);
        chk("t3_resp1_tag", 32'(resp_tag), 1);
        chk("t3_resp1_store", 32'(resp_is_store), 1);
        chk("t3_resp1_data", resp_data, 32'h0);
        tick();
        mem_resp_v = 0;
        #2;
        chk("t3_inflight_both", 32'(inflight), 1);
        chk("t3_head3_addr", mem_addr, 32'h10C);
        tick();
        mem_yumi = 0;
        #2;
        chk("t3_inflight2b", 32'(inflight), 2);
        chk("t3_mem_v_cap2", 32'(mem_v), 0);

        // Flush with two in flight and one queued
        req_v = 1; req_addr = 32'h200; req_tag = 4'd7; req_wen = 0;
        tick();
        req_v = 0;
        #2;
        chk("t4_busy_pre", 32'(busy), 1);
        flush = 1; req_v = 1; req_addr = 32'h300;
        #2;
        chk("t4_mem_v_flush", 32'(mem_v), 0);
        tick();
        flush = 0; req_v = 0; resp_ready = 0; mem_resp_v = 1; mem_resp_data = 32'h33333333;
        #2;
        chk("t4_resp_v_a", 32'(resp_v), 0);
        chk("t4_yumi_a", 32'(mem_resp_yumi), 1);
        tick();
        #2;
        chk("t4_resp_v_b", 32'(resp_v), 0);
        chk("t4_yumi_b", 32'(mem_resp_yumi), 1);
        chk("t4_mem_v_empty", 32'(mem_v), 0);
        tick();
        mem_resp_v = 0;
        #2;
        chk("t4_inflight0", 32'(inflight), 0);
        chk("t4_busy_post", 32'(busy), 0);

        // Spurious response
        mem_resp_v = 1; resp_ready = 1;
        #2;
        chk("t5_yumi", 32'(mem_resp_yumi), 0);
        chk("t5_resp_v", 32'(resp_v), 0);
        chk("t5_exc_pre", 32'(exception), 0);
        tick();
        mem_resp_v = 0;
        #2;
        chk("t5_exc_set", 32'(exception), 1);
        tick();
        tick();
        chk("t5_exc_sticky", 32'(exception), 1);

        // Reset while two requests are in flight
        req_v = 1; req_addr = 32'h400; req_tag = 4'd5;
        tick();
        req_addr = 32'h404; req_tag = 4'd6; mem_yumi = 1;
        #2;
        chk("t6_issue_a", mem_addr, 32'h400);
        tick();
        req_v = 0;
        #2;
        chk("t6_issue_b", mem_addr, 32'h404);
        tick();
        mem_yumi = 0;
        #2;
        chk("t6_inflight2", 32'(inflight), 2);
        mem_resp_v = 1; mem_resp_data = 32'h55;
        reset = 0;
        #1;
        chk("t6_ready", 32'(req_ready), 1);
        chk("t6_mem_v", 32'(mem_v), 0);
        chk("t6_resp_v", 32'(resp_v), 0);
        chk("t6_resp_yumi", 32'(mem_resp_yumi), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_inflight", 32'(inflight), 0);
        chk("t6_exc", 32'(exception), 0);
        mem_resp_v = 0;
        tick();
        tick();
        reset = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            #2;
            chk($sformatf("t6_no_resp_%0d", i), 32'(resp_v), 0);
            chk($sformatf("t6_idle_%0d", i), 32'(busy), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
